// File: rtl/can_bit_timing.sv
// can_bit_timing: bit-timing and sample-point generator for the CAN receive path.
// Oversamples Bus_Rx at one time quantum (tq) per Clock_TB cycle, hard-syncs on
// start-of-frame, resynchronises on recessive-to-dominant edges within SJW, and
// emits one sampled bit plus a one-cycle strobe per bit time.
// Optional build macro: CAN_TIMING_TRIPLE_SAMPLE_EN (2-of-3 majority sampling).
module can_bit_timing #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned SAMPLE_POINT = 7,
    parameter int unsigned SJW          = 2
) (
    input  logic Clock_TB,
    input  logic Reset,
    input  logic Bus_Rx,
    output logic Bit_Sample,
    output logic Sample_Strobe,
    output logic Bit_Start,
    output logic Bus_Idle
);

    localparam int unsigned CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] ONE_TQ   = CW'(1);
    localparam logic [CW-1:0] LAST_TQ  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SP_TQ    = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0] SJW_TQ   = CW'(SJW);
    localparam logic [CW-1:0] JUMP_TQ  = CW'(SJW + 1);
    // Early edges at or beyond this tq are within SJW of the next bit start
    localparam logic [CW-1:0] SNAP_TQ  = CW'(CLKS_PER_BIT - SJW);
    localparam logic [3:0]    IDLE_CNT = 4'd11;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } bus_state_t;

    typedef enum logic [2:0] {
        SYNC_NONE,
        SYNC_HARD,
        SYNC_AT_TQ0,
        SYNC_LATE,
        SYNC_EARLY_SNAP,
        SYNC_EARLY_JUMP
    } sync_t;

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [CW-1:0] r_tq;
    logic [3:0]    r_rec_cnt;
    logic          r_armed;
    logic          r_bit_sample;
    logic          r_strobe;
    logic          r_bit_start;
    bus_state_t    r_state;

    bus_state_t    w_state_nxt;
    logic          w_edge;
    sync_t         w_sync;
    logic [CW-1:0] w_tq_inc;
    logic [CW-1:0] w_tq_nxt;
    logic          w_sample_now;
    logic          w_sample_val;
    logic [3:0]    w_rec_nxt;

    assign w_edge       = !r_s2 && r_s3;
    // A sync in the sample-point cycle suppresses that cycle's sample
    assign w_sample_now = (r_tq == SP_TQ) && (w_sync == SYNC_NONE);

    // Bus_Rx synchroniser plus history flop for edge detection
    always_ff @(posedge Clock_TB or posedge Reset) begin
        if (Reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= Bus_Rx;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Classify the current edge: hard sync, one of the resync cases, or none
    always_comb begin
        w_sync = SYNC_NONE;
        if (w_edge) begin
            if (r_state == ST_IDLE) begin
                w_sync = SYNC_HARD;
            end else if (r_armed && r_bit_sample) begin
                if (r_tq == '0) begin
                    w_sync = SYNC_AT_TQ0;
                end else if (r_tq <= SP_TQ) begin
                    w_sync = SYNC_LATE;
                end else if (r_tq >= SNAP_TQ) begin
                    w_sync = SYNC_EARLY_SNAP;
                end else begin
                    w_sync = SYNC_EARLY_JUMP;
                end
            end
        end
    end

    // Next tq count: free-running wrap unless a sync moves it
    always_comb begin
        w_tq_inc = (r_tq == LAST_TQ) ? '0 : (r_tq + ONE_TQ);
        case (w_sync)
            SYNC_HARD, SYNC_EARLY_SNAP: w_tq_nxt = ONE_TQ;
            SYNC_LATE:                  w_tq_nxt = (r_tq <= SJW_TQ) ? ONE_TQ
                                                                    : (r_tq + ONE_TQ - SJW_TQ);
            SYNC_EARLY_JUMP:            w_tq_nxt = r_tq + JUMP_TQ;
            default:                    w_tq_nxt = w_tq_inc;
        endcase
    end

`ifdef CAN_TIMING_TRIPLE_SAMPLE_EN
    localparam logic [CW-1:0] WIN0_TQ = CW'(SAMPLE_POINT - 2);
    localparam logic [CW-1:0] WIN1_TQ = CW'(SAMPLE_POINT - 1);

    logic r_tri_a;
    logic r_tri_b;
    logic r_tri_ok;

    // Capture the two early window samples; any sync invalidates the window
    always_ff @(posedge Clock_TB or posedge Reset) begin
        if (Reset) begin
            r_tri_a  <= 1'b1;
            r_tri_b  <= 1'b1;
            r_tri_ok <= 1'b0;
        end else if (w_sync != SYNC_NONE) begin
            r_tri_ok <= 1'b0;
        end else if (r_tq == WIN0_TQ) begin
            r_tri_a  <= r_s2;
            r_tri_ok <= 1'b1;
        end else if (r_tq == WIN1_TQ) begin
            r_tri_b  <= r_s2;
        end else if (r_tq == SP_TQ) begin
            r_tri_ok <= 1'b0;
        end
    end

    // 2-of-3 majority; an interrupted window falls back to the single sample
    always_comb begin
        w_sample_val = r_s2;
        if (r_tri_ok) begin
            w_sample_val = (r_tri_a & r_tri_b) | (r_tri_a & r_s2) | (r_tri_b & r_s2);
        end
    end
`else
    // Single sample of the synchronised bus at the sample point
    always_comb begin
        w_sample_val = r_s2;
    end
`endif

    // Recessive run length after this strobe, saturating at the idle threshold
    always_comb begin
        w_rec_nxt = r_rec_cnt;
        if (!w_sample_val) begin
            w_rec_nxt = '0;
        end else if (r_rec_cnt < IDLE_CNT) begin
            w_rec_nxt = r_rec_cnt + 4'd1;
        end
    end

    // Bus state register
    always_ff @(posedge Clock_TB or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus state transitions: hard sync leaves idle, 11 recessive samples return
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sync == SYNC_HARD) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_sample_now && (w_rec_nxt == IDLE_CNT)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        Bus_Idle      = (r_state == ST_IDLE);
        Bit_Sample    = r_bit_sample;
        Sample_Strobe = r_strobe;
        Bit_Start     = r_bit_start;
    end

    // tq counter, strobes, sampled bit, resync arming and recessive count
    always_ff @(posedge Clock_TB or posedge Reset) begin
        if (Reset) begin
            r_tq         <= '0;
            r_rec_cnt    <= IDLE_CNT;
            r_armed      <= 1'b1;
            r_bit_sample <= 1'b1;
            r_strobe     <= 1'b0;
            r_bit_start  <= 1'b0;
        end else begin
            r_tq        <= w_tq_nxt;
            r_strobe    <= w_sample_now;
            r_bit_start <= (r_tq == '0) || (w_sync == SYNC_HARD)
                           || (w_sync == SYNC_EARLY_SNAP);
            if (w_sample_now) begin
                r_bit_sample <= w_sample_val;
            end
            if (w_sync != SYNC_NONE) begin
                r_armed <= 1'b0;
            end else if (w_sample_now) begin
                r_armed <= 1'b1;
            end
            if (w_sync == SYNC_HARD) begin
                r_rec_cnt <= '0;
            end else if (w_sample_now) begin
                r_rec_cnt <= w_rec_nxt;
            end
        end
    end

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed testbench for can_bit_timing with default timing 10/7/2.
// Every scenario starts from an observed strobe, where the tq counter is 8.
module tb_can_bit_timing;

    logic Clock_TB = 1'b0;
    logic Reset;
    logic Bus_Rx;
    logic Bit_Sample;
    logic Sample_Strobe;
    logic Bit_Start;
    logic Bus_Idle;

    int checks = 0;
    int errors = 0;

    can_bit_timing #(
        .CLKS_PER_BIT (10),
        .SAMPLE_POINT (7),
        .SJW          (2)
    ) dut (
        .Clock_TB      (Clock_TB),
        .Reset         (Reset),
        .Bus_Rx        (Bus_Rx),
        .Bit_Sample    (Bit_Sample),
        .Sample_Strobe (Sample_Strobe),
        .Bit_Start     (Bit_Start),
        .Bus_Idle      (Bus_Idle)
    );

    always #5 Clock_TB = ~Clock_TB;

    task automatic tick();
        @(posedge Clock_TB);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for the next strobe; returns cycles waited
    task automatic wait_strobe(input int limit, output int waited, output bit seen);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < limit) begin
            tick();
            waited++;
            if (Sample_Strobe === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Bus_Rx = 1'b1;
        ticks(3);
        checks++; if (Bit_Sample !== 1'b1)    begin errors++; $display("FAIL reset_bit_sample got %b want 1", Bit_Sample); end
        checks++; if (Sample_Strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", Sample_Strobe); end
        checks++; if (Bit_Start !== 1'b0)     begin errors++; $display("FAIL reset_bit_start got %b want 0", Bit_Start); end
        checks++; if (Bus_Idle !== 1'b1)      begin errors++; $display("FAIL reset_bus_idle got %b want 1", Bus_Idle); end
        Reset = 1'b0;
        // Free-running idle: Bit_Start at c==0 (cycle 1,11,21), strobe at cycle 8,18,28
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++; if (Bus_Idle !== 1'b1) begin errors++; $display("FAIL idle_hold cyc %0d got %b want 1", i, Bus_Idle); end
            checks++; if (Bit_Start !== ((i % 10) == 1)) begin errors++; $display("FAIL idle_bit_start cyc %0d got %b want %b", i, Bit_Start, (i % 10) == 1); end
            checks++; if (Sample_Strobe !== ((i % 10) == 8)) begin errors++; $display("FAIL idle_strobe cyc %0d got %b want %b", i, Sample_Strobe, (i % 10) == 8); end
        end
    endtask

    task automatic test_hard_sync();
        int n; bit seen;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 8) begin errors++; $display("FAIL idle_strobe_phase got %0d want 8", n); end
        checks++; if (Bit_Sample !== 1'b1) begin errors++; $display("FAIL idle_sample got %b want 1", Bit_Sample); end
        ticks(3);
        checks++; if (Bit_Start !== 1'b1) begin errors++; $display("FAIL idle_tq0 got %b want 1", Bit_Start); end
        Bus_Rx = 1'b0;
        ticks(2);
        checks++; if (Bit_Start !== 1'b0) begin errors++; $display("FAIL hs_early_start got %b want 0", Bit_Start); end
        checks++; if (Bus_Idle !== 1'b1)  begin errors++; $display("FAIL hs_early_idle got %b want 1", Bus_Idle); end
        tick();
        checks++; if (Bit_Start !== 1'b1) begin errors++; $display("FAIL hs_bit_start got %b want 1", Bit_Start); end
        checks++; if (Bus_Idle !== 1'b0)  begin errors++; $display("FAIL hs_bus_idle got %b want 0", Bus_Idle); end
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 7) begin errors++; $display("FAIL hs_first_strobe got %0d want 7", n); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL hs_sample got %b want 0", Bit_Sample); end
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 10) begin errors++; $display("FAIL hs_period got %0d want 10", n); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL hs_sample2 got %b want 0", Bit_Sample); end
    endtask

    task automatic test_late_resync_one();
        int n; bit seen;
        Bus_Rx = 1'b1;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 10 || Bit_Sample !== 1'b1) begin errors++; $display("FAIL late1_rec_bit got %0d/%b want 10/1", n, Bit_Sample); end
        ticks(1);
        Bus_Rx = 1'b0;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n + 1 != 11) begin errors++; $display("FAIL late1_spacing got %0d want 11", n + 1); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL late1_sample got %b want 0", Bit_Sample); end
    endtask

    task automatic test_late_resync_sjw();
        int n; bit seen;
        Bus_Rx = 1'b1;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 10 || Bit_Sample !== 1'b1) begin errors++; $display("FAIL late3_rec_bit got %0d/%b want 10/1", n, Bit_Sample); end
        ticks(3);
        Bus_Rx = 1'b0;
        ticks(2);
        Bus_Rx = 1'b1;
        ticks(2);
        Bus_Rx = 1'b0;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n + 7 != 12) begin errors++; $display("FAIL late3_spacing got %0d want 12", n + 7); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL late3_sample got %b want 0", Bit_Sample); end
    endtask

    task automatic test_early_resync();
        int n; bit seen;
        Bus_Rx = 1'b1;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 10 || Bit_Sample !== 1'b1) begin errors++; $display("FAIL early_rec_bit got %0d/%b want 10/1", n, Bit_Sample); end
        ticks(9);
        Bus_Rx = 1'b0;
        tick();
        checks++; if (Sample_Strobe !== 1'b1 || Bit_Sample !== 1'b1) begin errors++; $display("FAIL early_prev_strobe got %b/%b want 1/1", Sample_Strobe, Bit_Sample); end
        tick();
        checks++; if (Bit_Start !== 1'b0) begin errors++; $display("FAIL early_no_start got %b want 0", Bit_Start); end
        tick();
        checks++; if (Bit_Start !== 1'b1) begin errors++; $display("FAIL early_bit_start got %b want 1", Bit_Start); end
        wait_strobe(20, n, seen);
        checks++; if (!seen || n + 2 != 9) begin errors++; $display("FAIL early_spacing got %0d want 9", n + 2); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL early_sample got %b want 0", Bit_Sample); end
    endtask

    task automatic test_resync_at_sample_point();
        int n; bit seen;
        Bus_Rx = 1'b1;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 10 || Bit_Sample !== 1'b1) begin errors++; $display("FAIL sp_rec_bit got %0d/%b want 10/1", n, Bit_Sample); end
        ticks(7);
        Bus_Rx = 1'b0;
        ticks(3);
        checks++; if (Sample_Strobe !== 1'b0) begin errors++; $display("FAIL sp_suppressed got %b want 0", Sample_Strobe); end
        checks++; if (Bit_Sample !== 1'b1) begin errors++; $display("FAIL sp_held_sample got %b want 1", Bit_Sample); end
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 2) begin errors++; $display("FAIL sp_delayed_strobe got %0d want 2", n); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL sp_sample got %b want 0", Bit_Sample); end
    endtask

    task automatic test_glitch();
        int n; bit seen;
        ticks(6);
        Bus_Rx = 1'b1;
        tick();
        Bus_Rx = 1'b0;
        wait_strobe(20, n, seen);
        checks++; if (!seen || n + 7 != 10) begin errors++; $display("FAIL glitch_spacing got %0d want 10", n + 7); end
        checks++; if (Bit_Sample !== 1'b0) begin errors++; $display("FAIL glitch_sample got %b want 0", Bit_Sample); end
    endtask

    task automatic test_idle_recovery();
        int n; bit seen;
        Bus_Rx = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            wait_strobe(20, n, seen);
            checks++; if (!seen || n != 10 || Bit_Sample !== 1'b1) begin errors++; $display("FAIL rec_bit %0d got %0d/%b want 10/1", k, n, Bit_Sample); end
            checks++; if (Bus_Idle !== (k == 11)) begin errors++; $display("FAIL rec_idle %0d got %b want %b", k, Bus_Idle, k == 11); end
        end
        ticks(3);
        Bus_Rx = 1'b0;
        ticks(2);
        checks++; if (Bit_Start !== 1'b0 || Bus_Idle !== 1'b1) begin errors++; $display("FAIL rehs_pre got %b/%b want 0/1", Bit_Start, Bus_Idle); end
        tick();
        checks++; if (Bit_Start !== 1'b1 || Bus_Idle !== 1'b0) begin errors++; $display("FAIL rehs_sync got %b/%b want 1/0", Bit_Start, Bus_Idle); end
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 7 || Bit_Sample !== 1'b0) begin errors++; $display("FAIL rehs_strobe got %0d/%b want 7/0", n, Bit_Sample); end
    endtask

    task automatic test_reset_mid_frame();
        int n; bit seen;
        ticks(3);
        Reset = 1'b1;
        #1;
        checks++; if (Bit_Sample !== 1'b1)    begin errors++; $display("FAIL mid_reset_sample got %b want 1", Bit_Sample); end
        checks++; if (Bit_Start !== 1'b0)     begin errors++; $display("FAIL mid_reset_start got %b want 0", Bit_Start); end
        checks++; if (Sample_Strobe !== 1'b0) begin errors++; $display("FAIL mid_reset_strobe got %b want 0", Sample_Strobe); end
        checks++; if (Bus_Idle !== 1'b1)      begin errors++; $display("FAIL mid_reset_idle got %b want 1", Bus_Idle); end
        Bus_Rx = 1'b1;
        ticks(2);
        Reset  = 1'b0;
        Bus_Rx = 1'b0;
        tick();
        checks++; if (Bit_Start !== 1'b1) begin errors++; $display("FAIL mid_tq0 got %b want 1", Bit_Start); end
        tick();
        checks++; if (Bit_Start !== 1'b0 || Bus_Idle !== 1'b1) begin errors++; $display("FAIL mid_pre_sync got %b/%b want 0/1", Bit_Start, Bus_Idle); end
        tick();
        checks++; if (Bit_Start !== 1'b1 || Bus_Idle !== 1'b0) begin errors++; $display("FAIL mid_hard_sync got %b/%b want 1/0", Bit_Start, Bus_Idle); end
        wait_strobe(20, n, seen);
        checks++; if (!seen || n != 7 || Bit_Sample !== 1'b0) begin errors++; $display("FAIL mid_strobe got %0d/%b want 7/0", n, Bit_Sample); end
    endtask

    initial begin
        test_reset();
        test_hard_sync();
        test_late_resync_one();
        test_late_resync_sjw();
        test_early_resync();
        test_resync_at_sample_point();
        test_glitch();
        test_idle_recovery();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
